// File: rtl/ula_pkg.sv
// ============================================================================
// Module   : ula_pkg
// Brief    : Shared types and constants for the ULA bitwise logic unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ula_pkg;

    localparam int LARGURA_PADRAO = 16;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOT  = 3'b110,
        OP_PASS = 3'b111
    } op_logica_t;

endpackage

`default_nettype wire

// File: rtl/ula_logica_comb.sv
// ============================================================================
// Module   : ula_logica_comb
// Brief    : Combinational eight-operation bitwise logic core, LARGURA bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_logica_comb
    import ula_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
)
(
    input  logic [LARGURA-1:0] A,
    input  logic [LARGURA-1:0] B,
    input  logic [2:0]         OP,
    output logic [LARGURA-1:0] RESULTADO
);

    always_comb begin
        RESULTADO = '0;
        case (op_logica_t'(OP))
            OP_AND:  RESULTADO = A & B;
            OP_OR:   RESULTADO = A | B;
            OP_XOR:  RESULTADO = A ^ B;
            OP_NAND: RESULTADO = ~(A & B);
            OP_NOR:  RESULTADO = ~(A | B);
            OP_XNOR: RESULTADO = ~(A ^ B);
            OP_NOT:  RESULTADO = ~A;
            OP_PASS: RESULTADO = A;
            default: RESULTADO = A;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ula_logica_pipe.sv
// ============================================================================
// Module   : ula_logica_pipe
// Brief    : Two-stage valid/ready pipelined bitwise logic unit with optional
//            zero/parity flags (enabled by macro ULA_LOGICA_FLAGS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_logica_pipe
    import ula_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
)
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               ENTRADA_VALIDA,
    output logic               ENTRADA_PRONTA,
    input  logic [LARGURA-1:0] A,
    input  logic [LARGURA-1:0] B,
    input  logic [2:0]         OP,
    output logic [LARGURA-1:0] RESULTADO,
    output logic               SAIDA_VALIDA,
    input  logic               SAIDA_PRONTA,
    output logic               ZERO,
    output logic               PARIDADE
);

    logic               r_v1;
    logic [LARGURA-1:0] r_a1;
    logic [LARGURA-1:0] r_b1;
    logic [2:0]         r_op1;
    logic               r_v2;
    logic [LARGURA-1:0] r_res2;
    logic [LARGURA-1:0] w_res;
    logic               w_avanca1;
    logic               w_avanca2;

    // A stage may advance when it is empty or its downstream is advancing.
    assign w_avanca2      = !r_v2 | SAIDA_PRONTA;
    assign w_avanca1      = !r_v1 | w_avanca2;
    assign ENTRADA_PRONTA = w_avanca1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_v1  <= 1'b0;
            r_a1  <= '0;
            r_b1  <= '0;
            r_op1 <= '0;
        end else if (w_avanca1) begin
            r_v1 <= ENTRADA_VALIDA;
            if (ENTRADA_VALIDA) begin
                r_a1  <= A;
                r_b1  <= B;
                r_op1 <= OP;
            end
        end
    end

    ula_logica_comb #(
        .LARGURA   (LARGURA)
    ) u_comb (
        .A         (r_a1),
        .B         (r_b1),
        .OP        (r_op1),
        .RESULTADO (w_res)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_v2   <= 1'b0;
            r_res2 <= '0;
        end else if (w_avanca2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_res2 <= w_res;
            end
        end
    end

    assign SAIDA_VALIDA = r_v2;
    assign RESULTADO    = r_res2;

`ifdef ULA_LOGICA_FLAGS_EN
    logic r_zero2;
    logic r_par2;

    // Flags travel with the result so they are held under backpressure too.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_zero2 <= 1'b0;
            r_par2  <= 1'b0;
        end else if (w_avanca2 && r_v1) begin
            r_zero2 <= (w_res == '0);
            r_par2  <= ^w_res;
        end
    end

    assign ZERO     = r_zero2;
    assign PARIDADE = r_par2;
`else
    assign ZERO     = 1'b0;
    assign PARIDADE = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ula_logica_pipe.sv
// ============================================================================
// Module   : tb_ula_logica_pipe
// Brief    : Self-checking bench: directed table, backpressure, reset and
//            randomized streams at widths 16, 8 and 32 against a truth-table model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ula_logica_pipe;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, req);
        end
    endtask

    // Per-bit truth table indexed by {a_bit, b_bit}, one row per opcode.
    function automatic logic [31:0] ref_op(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input logic [2:0] o);
        logic [3:0]  tt [8];
        logic [3:0]  row;
        logic [31:0] r;
        tt  = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
        row = tt[o];
        r   = '0;
        for (int i = 0; i < w; i++) r[i] = row[{x[i], y[i]}];
        return r;
    endfunction

    function automatic logic [1:0] ref_flags(input logic [31:0] r);
`ifdef ULA_LOGICA_FLAGS_EN
        return {(r == 32'd0), ^r};
`else
        return 2'b00;
`endif
    endfunction

    function automatic logic [17:0] exp16(input logic [15:0] x, input logic [15:0] y,
                                          input logic [2:0] o);
        logic [31:0] r;
        r = ref_op(16, {16'd0, x}, {16'd0, y}, o);
        return {ref_flags(r), r[15:0]};
    endfunction

    // ---------------- 16-bit DUT ----------------
    logic        rst, ev, ep, sv, sp, z, p;
    logic [15:0] a, b, res;
    logic [2:0]  op;

    ula_logica_pipe #(.LARGURA(16)) dut (
        .CLK            (CLK),
        .RST            (rst),
        .ENTRADA_VALIDA (ev),
        .ENTRADA_PRONTA (ep),
        .A              (a),
        .B              (b),
        .OP             (op),
        .RESULTADO      (res),
        .SAIDA_VALIDA   (sv),
        .SAIDA_PRONTA   (sp),
        .ZERO           (z),
        .PARIDADE       (p)
    );

    logic [17:0] q16 [$];

    // One cycle: drive after the falling edge, then predict the coming rising edge.
    task automatic cycle16(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                           input logic [2:0] iop, input logic isp, output logic acc);
        logic [17:0] e;
        @(negedge CLK);
        ev = v; a = ia; b = ib; op = iop; sp = isp;
        #1;
        if (sv && sp) begin
            if (q16.size() == 0) begin
                check("spurious16", 64'd1, 64'd0);
            end else begin
                e = q16.pop_front();
                check("res16", res, e[15:0]);
                check("flags16", {z, p}, e[17:16]);
            end
        end
        acc = ev && ep;
        if (acc) q16.push_back(exp16(ia, ib, iop));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ez;
        logic        epar;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic        acc;
        logic        have;
        logic [15:0] pa, pb, hold0;
        logic [2:0]  po;
        logic [15:0] bpa [5];
        logic [15:0] bpb [5];
        logic [2:0]  bpo [5];
        int          idx;

        tbl[0] = '{3'b000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
        tbl[1] = '{3'b001, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0};
        tbl[2] = '{3'b010, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0};
        tbl[3] = '{3'b011, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0};
        tbl[4] = '{3'b100, 16'hF0F0, 16'hFF00, 16'h000F, 1'b0, 1'b0};
        tbl[5] = '{3'b101, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 1'b0};
        tbl[6] = '{3'b110, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0, 1'b0};
        tbl[7] = '{3'b111, 16'hF0F0, 16'hFF00, 16'hF0F0, 1'b0, 1'b0};
        tbl[8] = '{3'b010, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
        tbl[9] = '{3'b111, 16'h0007, 16'hABCD, 16'h0007, 1'b0, 1'b1};

        rst = 1'b1; ev = 1'b0; sp = 1'b1; a = '0; b = '0; op = '0;

        // Reset / idle
        repeat (2) @(negedge CLK);
        check("rst_sv", sv, 0);
        check("rst_res", res, 0);
        check("rst_ep", ep, 1);
        rst = 1'b0;
        @(negedge CLK);
        check("idle_ep", ep, 1);
        check("idle_sv", sv, 0);

        // Opcode sweep: one result per cycle, two edges after acceptance
        for (int j = 0; j < 13; j++) begin
            @(negedge CLK);
            if (j >= 2 && j < 12) begin
                check($sformatf("tbl%0d_sv", j - 2), sv, 1);
                check($sformatf("tbl%0d_res", j - 2), res, tbl[j - 2].res);
`ifdef ULA_LOGICA_FLAGS_EN
                check($sformatf("tbl%0d_flags", j - 2), {z, p}, {tbl[j - 2].ez, tbl[j - 2].epar});
`else
                check($sformatf("tbl%0d_flags", j - 2), {z, p}, 2'b00);
`endif
            end
            if (j == 12) check("tbl_drain_sv", sv, 0);
            if (j < 10) begin
                ev = 1'b1; a = tbl[j].a; b = tbl[j].b; op = tbl[j].op;
            end else begin
                ev = 1'b0;
            end
        end

        // Backpressure: five items, consumer stalled
        for (int k = 0; k < 5; k++) begin
            bpa[k] = 16'($urandom); bpb[k] = 16'($urandom); bpo[k] = 3'($urandom);
        end
        cycle16(1'b1, bpa[0], bpb[0], bpo[0], 1'b0, acc);
        check("bp_acc0", acc, 1);
        cycle16(1'b1, bpa[1], bpb[1], bpo[1], 1'b0, acc);
        check("bp_acc1", acc, 1);
        hold0 = q16[0][15:0];
        for (int k = 0; k < 3; k++) begin
            cycle16(1'b1, bpa[2], bpb[2], bpo[2], 1'b0, acc);
            check("bp_full_acc", acc, 0);
            check("bp_full_ep", ep, 0);
            check("bp_hold_sv", sv, 1);
            check("bp_hold_res", res, hold0);
        end
        idx = 2;
        for (int c = 0; c < 20 && (idx < 5 || q16.size() > 0); c++) begin
            if (idx < 5) cycle16(1'b1, bpa[idx], bpb[idx], bpo[idx], 1'b1, acc);
            else         cycle16(1'b0, '0, '0, '0, 1'b1, acc);
            if (acc) idx++;
        end
        check("bp_all_in", idx, 5);
        check("bp_all_out", q16.size(), 0);
        cycle16(1'b0, '0, '0, '0, 1'b1, acc);
        check("bp_empty_sv", sv, 0);

        // Simultaneous shift+accept on a full pipe, then asynchronous reset
        cycle16(1'b1, 16'h1111, 16'h2222, 3'b001, 1'b0, acc);
        cycle16(1'b1, 16'h3333, 16'h0F0F, 3'b010, 1'b0, acc);
        cycle16(1'b1, 16'h5555, 16'hAAAA, 3'b000, 1'b1, acc);
        check("simul_acc", acc, 1);
        cycle16(1'b0, '0, '0, '0, 1'b0, acc);
        check("simul_sv", sv, 1);
        check("simul_full_ep", ep, 0);
        check("simul_q", q16.size(), 2);

        @(negedge CLK);
        rst = 1'b1;
        #1;
        check("arst_sv", sv, 0);
        check("arst_res", res, 0);
        check("arst_ep", ep, 1);
        q16.delete();
        @(negedge CLK);
        rst = 1'b0;
        cycle16(1'b1, 16'hC3C3, 16'h0FF0, 3'b101, 1'b1, acc);
        check("post_rst_acc", acc, 1);
        cycle16(1'b0, '0, '0, '0, 1'b1, acc);
        check("post_rst_lat1", sv, 0);
        cycle16(1'b0, '0, '0, '0, 1'b1, acc);
        check("post_rst_lat2", sv, 1);
        check("post_rst_q", q16.size(), 0);

        // Randomized 16-bit stream
        have = 1'b0; pa = '0; pb = '0; po = '0;
        for (int c = 0; c < 400; c++) begin
            if (c < 350 && !have) begin
                have = ($urandom_range(0, 3) != 0);
                pa = 16'($urandom); pb = 16'($urandom); po = 3'($urandom);
            end
            cycle16(have, pa, pb, po, (c >= 350) ? 1'b1 : 1'($urandom_range(0, 1)), acc);
            if (acc) have = 1'b0;
        end
        check("rand16_drain", q16.size(), 0);

        for (int c = 0; c < 5000 && !(g_larg[0].gdone && g_larg[1].gdone); c++) @(negedge CLK);
        check("width_streams_done", {g_larg[0].gdone, g_larg[1].gdone}, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- 8-bit and 32-bit DUTs, random traffic ----------------
    for (genvar g = 0; g < 2; g++) begin : g_larg
        localparam int W = (g == 0) ? 8 : 32;

        logic         grst, gev, gep, gsv, gsp, gz, gp;
        logic [W-1:0] ga, gb, gres;
        logic [2:0]   gop;
        logic         gdone = 1'b0;
        logic [W+1:0] q [$];

        ula_logica_pipe #(.LARGURA(W)) dut_w (
            .CLK            (CLK),
            .RST            (grst),
            .ENTRADA_VALIDA (gev),
            .ENTRADA_PRONTA (gep),
            .A              (ga),
            .B              (gb),
            .OP             (gop),
            .RESULTADO      (gres),
            .SAIDA_VALIDA   (gsv),
            .SAIDA_PRONTA   (gsp),
            .ZERO           (gz),
            .PARIDADE       (gp)
        );

        initial begin
            logic [31:0]  r;
            logic [W+1:0] e;
            logic         have;
            grst = 1'b1; gev = 1'b0; gsp = 1'b0; ga = '0; gb = '0; gop = '0; have = 1'b0;
            repeat (2) @(negedge CLK);
            grst = 1'b0;
            for (int c = 0; c < 600; c++) begin
                @(negedge CLK);
                if (c < 550 && !have) begin
                    have = ($urandom_range(0, 3) != 0);
                    ga = W'($urandom); gb = W'($urandom); gop = 3'($urandom);
                end
                gev = have;
                gsp = (c >= 550) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                if (gsv && gsp) begin
                    if (q.size() == 0) begin
                        check($sformatf("spurious_w%0d", W), 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("res_w%0d", W), gres, e[W-1:0]);
                        check($sformatf("flags_w%0d", W), {gz, gp}, e[W+1:W]);
                    end
                end
                if (gev && gep) begin
                    r = ref_op(W, 32'(ga), 32'(gb), gop);
                    e = {ref_flags(r), r[W-1:0]};
                    q.push_back(e);
                    have = 1'b0;
                end
            end
            check($sformatf("drain_w%0d", W), q.size(), 0);
            gdone = 1'b1;
        end
    end

endmodule

`default_nettype wire
